bram_line_unpacker: RTL and testbench

- Readback/drain path: the transmit-side counterpart of the pipe-in packer that builds BURST_LEN x 16-bit BRAM lines.
- Reads a run of 16*BURST_LEN-bit lines from a BRAM read port and serialises each line lane by lane, lane 0 (bits [15:0]) first.
- Each lane is written into a 32-bit FIFO as one zero-extended word. The FIFO feeds okBTPipeOut.
- Sits in the sys_clk domain between a data/weight/bias BRAM port B and the result FIFO write side. Used for host-side verification of loaded RAM contents.

---
 rtl/bram_line_unpacker.sv | 139 +++++++++++++
 tb/tb_bram_line_unpacker.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_line_unpacker.sv
// bram_line_unpacker: drains a run of BRAM lines into a 32-bit FIFO.
// Each 16*BURST_LEN-bit line is emitted lane by lane, lane 0 first, with
// every lane zero-extended to one FIFO word. Writes stall while the FIFO is
// full or within HEADROOM words of FIFO_DEPTH.
//
// state  | meaning
// S_IDLE | waiting for start; parameters latched on an accepted start
// S_READ | ram_addr presented for the current line
// S_LOAD | BRAM data captured into the lane shift register
// S_EMIT | one lane per unblocked cycle written to the FIFO
// S_DONE | one-cycle completion pulse
module bram_line_unpacker #(
  parameter int BURST_LEN  = 8,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 1023,
  parameter int HEADROOM   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W:0]         line_count,
  output logic [ADDR_W-1:0]       ram_addr,
  input  logic [16*BURST_LEN-1:0] ram_dout,
  output logic [31:0]             fifo_din,
  output logic                    fifo_wr_en,
  input  logic                    fifo_full,
  input  logic [9:0]              fifo_wr_count,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             words_sent
);

  localparam int LANE_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int LINE_W = 16 * BURST_LEN;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BURST_LEN - 1);
  // Occupancy at which writes pause; the slack absorbs wr_count lag.
  localparam int unsigned BLOCK_LEVEL = FIFO_DEPTH - HEADROOM;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_EMIT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] line_addr;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [ADDR_W:0]   lines_left;
  logic [LINE_W-1:0] shift_reg;
  logic [LANE_W-1:0] lane_cnt;
  logic [15:0]       words_cnt;
  logic              blocked;
  logic              last_lane;

  assign blocked   = fifo_full | (32'(fifo_wr_count) >= BLOCK_LEVEL);
  assign last_lane = (lane_cnt == LAST_LANE);

  assign fifo_din   = {16'h0000, shift_reg[15:0]};
  assign words_sent = words_cnt;
  // The address is live during READ and parked on its last value otherwise.
  assign ram_addr   = (state == S_READ) ? line_addr : ram_addr_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and FSM-driven strobes.
  always_comb begin
    state_nxt  = state;
    fifo_wr_en = 1'b0;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (line_count != '0) ? S_READ : S_DONE;
      end
      S_READ: state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_EMIT;
      S_EMIT: begin
        if (!blocked) begin
          fifo_wr_en = 1'b1;
          if (last_lane)
            state_nxt = (lines_left == (ADDR_W+1)'(1)) ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: run parameters, lane shifter and word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_addr  <= '0;
      ram_addr_q <= '0;
      lines_left <= '0;
      shift_reg  <= '0;
      lane_cnt   <= '0;
      words_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            line_addr  <= base_addr;
            lines_left <= line_count;
            words_cnt  <= '0;
          end
        end
        S_READ: ram_addr_q <= line_addr;
        S_LOAD: begin
          shift_reg <= ram_dout;
          lane_cnt  <= '0;
        end
        S_EMIT: begin
          if (fifo_wr_en) begin
            shift_reg <= shift_reg >> 16;
            lane_cnt  <= lane_cnt + LANE_W'(1);
            if (words_cnt != 16'hFFFF) words_cnt <= words_cnt + 16'd1;
            if (last_lane) begin
              lines_left <= lines_left - (ADDR_W+1)'(1);
              line_addr  <= line_addr + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_line_unpacker.sv
// Directed bench for bram_line_unpacker with a 1024-line BRAM model.
module tb_bram_line_unpacker;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [9:0]   base_addr = '0;
  logic [10:0]  line_count = '0;
  logic [9:0]   ram_addr;
  logic [127:0] ram_dout;
  logic [31:0]  fifo_din;
  logic         fifo_wr_en;
  logic         fifo_full = 1'b0;
  logic [9:0]   fifo_wr_count = '0;
  logic         busy;
  logic         done;
  logic [15:0]  words_sent;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [127:0] mem [0:1023];
  logic [31:0]  wr_q[$];
  int           wr_cyc[$];
  logic [9:0]   addr_q[$];
  logic [9:0]   last_addr = '0;
  int           done_cnt = 0;
  int           done_cyc = -1;
  int           t0;

  bram_line_unpacker #(.BURST_LEN(8), .ADDR_W(10), .FIFO_DEPTH(1023), .HEADROOM(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .line_count(line_count), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
    .fifo_wr_count(fifo_wr_count), .busy(busy), .done(done),
    .words_sent(words_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) ram_dout <= mem[ram_addr];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(int line, int lane);
    logic [15:0] v;
    v = 16'((line % 1024) * 16 + lane + 1);
    return {16'h0000, v};
  endfunction

  // Monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (fifo_wr_en) begin
      wr_q.push_back(fifo_din);
      wr_cyc.push_back(cyc);
      chk("wr_while_blocked", {31'b0, fifo_full | (fifo_wr_count >= 10'd1019)}, 32'd0);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (ram_addr !== last_addr) begin
      addr_q.push_back(ram_addr);
      last_addr = ram_addr;
    end
  end

  task automatic clear_logs();
    wr_q.delete();
    wr_cyc.delete();
    addr_q.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic do_start(input int b, input int n, output int t_acc);
    base_addr  = 10'(b);
    line_count = 11'(n);
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t_acc = cyc;
  endtask

  task automatic wait_done(string tag, int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > 0) break;
      @(posedge clk); #1;
    end
    chk({tag, "_done_seen"}, {31'b0, done_cnt > 0}, 32'd1);
    chk({tag, "_idle_after"}, {31'b0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_once"}, done_cnt, 32'd1);
  endtask

  task automatic check_run(string tag, int b, int n);
    int bad;
    bad = 0;
    chk({tag, "_word_count"}, wr_q.size(), n * 8);
    for (int i = 0; i < n * 8; i++) begin
      if (i < wr_q.size()) begin
        if (n <= 3) chk($sformatf("%s_w%0d", tag, i), wr_q[i], exp_word(b + i / 8, i % 8));
        else if (wr_q[i] !== exp_word(b + i / 8, i % 8)) bad++;
      end
    end
    if (n > 3) chk({tag, "_data_bad"}, bad, 32'd0);
    chk({tag, "_words_sent"}, {16'h0, words_sent}, n * 8);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++)
      for (int k = 0; k < 8; k++)
        mem[i][k*16 +: 16] = 16'(i * 16 + k + 1);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", {31'b0, fifo_wr_en}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_words", {16'h0, words_sent}, 32'd0);
    chk("rst_addr", {22'h0, ram_addr}, 32'd0);
    chk("rst_din", fifo_din, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single line, latency and timing
    clear_logs();
    do_start(0, 1, t0);
    chk("t1_busy", {31'b0, busy}, 32'd1);
    wait_done("t1", 40);
    check_run("t1", 0, 1);
    if (wr_cyc.size() == 8) begin
      chk("t1_first_wr_cyc", wr_cyc[0], t0 + 2);
      chk("t1_last_wr_cyc", wr_cyc[7], t0 + 9);
    end
    chk("t1_done_cyc", done_cyc, t0 + 10);

    // Three lines from base 5; a start while busy is ignored
    clear_logs();
    do_start(5, 3, t0);
    base_addr  = 10'd100;
    line_count = 11'd1;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t2", 100);
    check_run("t2", 5, 3);
    chk("t2_addr_n", addr_q.size(), 32'd3);
    if (addr_q.size() == 3) begin
      chk("t2_addr0", {22'h0, addr_q[0]}, 32'd5);
      chk("t2_addr1", {22'h0, addr_q[1]}, 32'd6);
      chk("t2_addr2", {22'h0, addr_q[2]}, 32'd7);
    end
    if (wr_cyc.size() == 24) begin
      chk("t2_gap1", wr_cyc[8] - wr_cyc[7], 32'd3);
      chk("t2_gap2", wr_cyc[16] - wr_cyc[15], 32'd3);
    end
    chk("t2_done_cyc", done_cyc, t0 + 30);

    // Address wrap 1023 -> 0
    clear_logs();
    do_start(1023, 2, t0);
    wait_done("t3", 60);
    check_run("t3", 1023, 2);
    chk("t3_addr_n", addr_q.size(), 32'd2);
    if (addr_q.size() == 2) begin
      chk("t3_addr0", {22'h0, addr_q[0]}, 32'd1023);
      chk("t3_addr1", {22'h0, addr_q[1]}, 32'd0);
    end

    // Backpressure: count threshold, boundary just below, then fifo_full
    clear_logs();
    do_start(2, 1, t0);
    for (int i = 0; i < 50; i++) begin
      if (wr_q.size() >= 3) break;
      @(posedge clk); #1;
    end
    chk("t4_pre_words", wr_q.size(), 32'd3);
    fifo_wr_count = 10'd1019;
    repeat (5) @(posedge clk);
    #1;
    chk("t4_held_count", wr_q.size(), 32'd3);
    fifo_wr_count = 10'd1018;
    repeat (2) @(posedge clk);
    #1;
    chk("t4_below_level", wr_q.size(), 32'd5);
    fifo_wr_count = 10'd0;
    fifo_full     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t4_held_full", wr_q.size(), 32'd5);
    fifo_full = 1'b0;
    wait_done("t4", 40);
    check_run("t4", 2, 1);

    // Zero-length run
    clear_logs();
    do_start(50, 0, t0);
    wait_done("t5", 10);
    chk("t5_done_cyc", done_cyc, t0);
    chk("t5_no_writes", wr_q.size(), 32'd0);
    chk("t5_words", {16'h0, words_sent}, 32'd0);

    // Reset mid-run after three words
    clear_logs();
    do_start(20, 2, t0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (wr_q.size() >= 3) break;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_wr_en", {31'b0, fifo_wr_en}, 32'd0);
    chk("t6_busy", {31'b0, busy}, 32'd0);
    chk("t6_words", {16'h0, words_sent}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("t6_partial_words", wr_q.size(), 32'd3);
    chk("t6_no_done", done_cnt, 32'd0);

    // start and rst together: rst wins
    base_addr  = 10'd30;
    line_count = 11'd1;
    start      = 1'b1;
    rst        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rst   = 1'b0;
    chk("t6_rst_wins_busy", {31'b0, busy}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("t6_rst_wins_writes", wr_q.size(), 32'd3);

    // Replay from a new base
    clear_logs();
    do_start(9, 1, t0);
    wait_done("t6r", 40);
    check_run("t6r", 9, 1);

    // Whole-RAM drain
    clear_logs();
    do_start(0, 1024, t0);
    wait_done("t7", 11000);
    check_run("t7", 0, 1024);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
